bash_cmd_exec: RTL



---
 rtl/bash_pkg.sv | 23 ++
 rtl/bash_str_rom.sv | 22 ++
 rtl/bash_cmd_exec.sv | 175 +++++++++++++++++
 3 files changed

// File: rtl/bash_pkg.sv
// Shared types, limits and reply strings for the bash command executor.
// Pure declarations: no logic, no timing.
package bash_pkg;

    localparam int MAX_CMD_LEN   = 32;
    localparam int MAX_REPLY_LEN = 64;
    localparam int HELLO_LEN     = 18;
    localparam int UNK_LEN       = 17;

    localparam logic [8*HELLO_LEN-1:0] HELLO_STR = "Hello from SSshell";
    localparam logic [8*UNK_LEN-1:0]   UNK_STR   = "unknown command: ";
    localparam logic [8*5-1:0]         ECHO_KW   = "echo ";
    localparam logic [8*5-1:0]         HELLO_KW  = "hello";
    localparam logic [8*6-1:0]         UPPER_KW  = "upper ";

    typedef enum logic [2:0] {IDLE, RX, RX_DRAIN, PARSE, BUILD, TX, SOLVE} state_t;
    typedef enum logic [2:0] {K_NONE, K_ECHO, K_HELLO, K_UNKNOWN, K_UPPER} rsp_kind_t;

    function automatic logic [7:0] to_upper(input logic [7:0] c);
        return (c >= 8'h61 && c <= 8'h7a) ? c - 8'h20 : c;
    endfunction

endpackage

// File: rtl/bash_str_rom.sv
// Combinational index -> byte lookup of the fixed reply strings; zero latency,
// no flow control. Out-of-range indices read as 0.
module bash_str_rom
    import bash_pkg::*;
(
    input  logic       sel_hello,
    input  logic [4:0] idx,
    output logic [7:0] data
);

    always_comb begin
        data = 8'h00;
        if (sel_hello) begin
            if (idx < 5'(HELLO_LEN))
                data = HELLO_STR[8*(HELLO_LEN-1-int'(idx)) +: 8];
        end else begin
            if (idx < 5'(UNK_LEN))
                data = UNK_STR[8*(UNK_LEN-1-int'(idx)) +: 8];
        end
    end

endmodule

// File: rtl/bash_cmd_exec.sv
// Pulls a line from the terminal, decodes it, streams a 0-terminated reply, then waits in SOLVE;
// empty line reaches in_solved 3 cycles after ready. TX holds on terminal stall. CMD_UPPER_EN adds "upper".
module bash_cmd_exec
    import bash_pkg::*;
(
    input  logic       clk,
    input  logic       clrn,
    input  logic       out_newASCII_ready,
    input  logic [5:0] out_lineLen,
    input  logic [7:0] lineOut,
    output logic       lineOut_nextASCII,
    output logic [7:0] lineIn,
    output logic       in_newASCII_ready,
    input  logic       lineIn_nextASCII,
    output logic       in_solved,
    input  logic       out_solved,
    output logic       busy
);

    state_t     state;
    rsp_kind_t  kind;
    rsp_kind_t  dec_kind;
    logic [5:0] len;
    logic [5:0] rx_cnt;
    logic       rx_gap;
    logic [6:0] tx_len;
    logic [6:0] tx_idx;
    logic [6:0] raw_len;
    logic [6:0] clen;
    logic [7:0] build_byte;
    logic [7:0] rom_dat;
    logic [4:0] e_idx;
    logic [4:0] u_idx;
    logic       is_echo;
    logic       is_hello;
    logic       is_upper;
    logic [7:0] cmd [MAX_CMD_LEN];
    logic [7:0] rsp [MAX_REPLY_LEN+1];

    assign busy  = (state != IDLE);
    assign e_idx = tx_len[4:0] + 5'd5;
    assign u_idx = tx_len[4:0] - 5'd17;

    bash_str_rom u_rom (
        .sel_hello (kind == K_HELLO),
        .idx       (tx_len[4:0]),
        .data      (rom_dat)
    );

    always_comb begin
        is_echo  = (len >= 6'd5) && ({cmd[0], cmd[1], cmd[2], cmd[3], cmd[4]} == ECHO_KW);
        is_hello = (len == 6'd5) && ({cmd[0], cmd[1], cmd[2], cmd[3], cmd[4]} == HELLO_KW);
`ifdef CMD_UPPER_EN
        is_upper = (len >= 6'd6) && ({cmd[0], cmd[1], cmd[2], cmd[3], cmd[4], cmd[5]} == UPPER_KW);
`else
        is_upper = 1'b0;
`endif
        if (len == 6'd0)   dec_kind = K_NONE;
        else if (is_echo)  dec_kind = K_ECHO;
        else if (is_hello) dec_kind = K_HELLO;
        else if (is_upper) dec_kind = K_UPPER;
        else               dec_kind = K_UNKNOWN;
    end

    // Reply content length (terminator excluded) and the byte for position tx_len.
    always_comb begin
        raw_len    = 7'd0;
        build_byte = 8'h00;
        case (kind)
            K_ECHO: begin
                raw_len    = {1'b0, len} - 7'd5;
                build_byte = cmd[e_idx];
            end
            K_HELLO: begin
                raw_len    = 7'(HELLO_LEN);
                build_byte = rom_dat;
            end
            K_UNKNOWN: begin
                raw_len    = 7'(UNK_LEN) + {1'b0, len};
                build_byte = (tx_len < 7'(UNK_LEN)) ? rom_dat : cmd[u_idx];
            end
`ifdef CMD_UPPER_EN
            K_UPPER: begin
                raw_len    = {1'b0, len} - 7'd6;
                build_byte = to_upper(cmd[tx_len[4:0] + 5'd6]);
            end
`endif
            default: begin
                raw_len    = 7'd0;
                build_byte = 8'h00;
            end
        endcase
        clen = (raw_len > 7'(MAX_REPLY_LEN)) ? 7'(MAX_REPLY_LEN) : raw_len;
    end

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            state             <= IDLE;
            kind              <= K_NONE;
            len               <= '0;
            rx_cnt            <= '0;
            rx_gap            <= 1'b0;
            tx_len            <= '0;
            tx_idx            <= '0;
            lineOut_nextASCII <= 1'b0;
            lineIn            <= 8'h00;
            in_newASCII_ready <= 1'b0;
            in_solved         <= 1'b0;
            for (int i = 0; i < MAX_CMD_LEN; i++)     cmd[i] <= 8'h00;
            for (int i = 0; i <= MAX_REPLY_LEN; i++)  rsp[i] <= 8'h00;
        end else begin
            lineOut_nextASCII <= 1'b0;
            case (state)
                IDLE: if (out_newASCII_ready) begin
                    len    <= (out_lineLen > 6'(MAX_CMD_LEN)) ? 6'(MAX_CMD_LEN) : out_lineLen;
                    rx_cnt <= '0;
                    rx_gap <= 1'b0;
                    state  <= RX;
                end
                // Every sample is followed by a gap so the terminal can advance its index.
                RX: if (rx_gap) begin
                    rx_gap <= 1'b0;
                end else if (rx_cnt == len) begin
                    state <= (len == 6'd0) ? PARSE : RX_DRAIN;
                end else if (lineOut == 8'h00) begin
                    len   <= rx_cnt;
                    state <= RX_DRAIN;
                end else begin
                    cmd[rx_cnt[4:0]]  <= lineOut;
                    rx_cnt            <= rx_cnt + 6'd1;
                    lineOut_nextASCII <= 1'b1;
                    rx_gap            <= 1'b1;
                end
                RX_DRAIN: if (!out_newASCII_ready) state <= PARSE;
                PARSE: begin
                    kind   <= dec_kind;
                    tx_len <= '0;
                    tx_idx <= '0;
                    if (dec_kind == K_NONE) begin
                        in_solved <= 1'b1;
                        state     <= SOLVE;
                    end else begin
                        state <= BUILD;
                    end
                end
                BUILD: if (tx_len == clen) begin
                    rsp[tx_len]       <= 8'h00;
                    lineIn            <= (tx_len == 7'd0) ? 8'h00 : rsp[0];
                    in_newASCII_ready <= 1'b1;
                    state             <= TX;
                end else begin
                    rsp[tx_len] <= build_byte;
                    tx_len      <= tx_len + 7'd1;
                end
                TX: if (lineIn_nextASCII) begin
                    if (tx_idx == tx_len) begin
                        in_newASCII_ready <= 1'b0;
                        lineIn            <= 8'h00;
                        in_solved         <= 1'b1;
                        state             <= SOLVE;
                    end else begin
                        tx_idx <= tx_idx + 7'd1;
                        lineIn <= rsp[tx_idx + 7'd1];
                    end
                end
                SOLVE: if (out_solved) begin
                    in_solved <= 1'b0;
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
